ber_mode_seq: RTL and testbench
===============================

# ber_mode_seq

Sequencer that sweeps the stimulus mode decoder through a programmed range of MAIN_MODE/SUB_MODE pairs for BER characterisation. For each pair it drives the mode and waits a settle period. It then opens a measurement window toward the BER counter and waits for that counter's completion acknowledge before stepping on. It sits between the register/host interface and the stimulus block, and replaces static MAIN_MODE/SUB_MODE register writes.

## Interface
- SETTLE_CYC, 4: cycles between a mode change and MEAS_REQ rise; covers stimulus register latency and settling; legal values ≥2.
- DWELL_W, 16: width of the dwell counter.
- ACK_TMO, 1024: maximum cycles in WAIT_ACK before a timeout error.

- CLK  in  1  clock
- RSTX  in  1  reset; asynchronous, active-low
- START  in  1  one-cycle pulse; begin a sweep
- ABORT  in  1  level/pulse; stop the sweep immediately
- MAIN_FIRST  in  8  first main mode
- MAIN_LAST  in  8  last main mode
- SUB_LAST  in  8  sub mode sweeps 0..SUB_LAST
- DWELL  in  DWELL_W  measurement window length in cycles; 0 treated as 1
- MEAS_ACK  in  1  BER counter finished the window; pulse
- MAIN_MODE  out  8  to stimulus
- SUB_MODE  out  8  to stimulus
- MEAS_REQ  out  1  high during the measurement window
- BUSY  out  1  high whenever state ≠ IDLE
- DONE  out  1  one-cycle pulse; sweep completed normally
- ERR  out  2  one-cycle code: 01 bad config, 10 ack timeout; otherwise 00

## Operation
- States: IDLE, SETTLE, MEAS, WAIT_ACK.
- IDLE:
  - MAIN_MODE=0, SUB_MODE=0; code 0 decodes to the stimulus "unable" value.
  - START is accepted only when 9 ≤ MAIN_FIRST ≤ MAIN_LAST ≤ 31.
  - Valid START: latch MAIN_LAST, SUB_LAST and DWELL; set main=MAIN_FIRST, sub=0; go to SETTLE.
  - Invalid START: ERR=01 for 1 cycle; remain in IDLE.
- SETTLE: count SETTLE_CYC cycles, then go to MEAS.
- MEAS: MEAS_REQ=1 for max(DWELL,1) cycles, then go to WAIT_ACK.
- WAIT_ACK:
  - MEAS_REQ=0.
  - On MEAS_ACK:
    - If main==MAIN_LAST and sub==SUB_LAST: DONE=1 for 1 cycle; go to IDLE.
    - Else if sub<SUB_LAST: sub+1.
    - Else: sub=0, main+1.
    - When not finished, go to SETTLE.
  - If ACK_TMO cycles elapse without MEAS_ACK: ERR=10 for 1 cycle; go to IDLE.
- MEAS_ACK outside WAIT_ACK is ignored; it is not queued.
- START while BUSY is ignored. Input config changes while BUSY have no effect because config is latched.
- ABORT in any non-IDLE state: next cycle is IDLE with modes 0 and MEAS_REQ 0; no DONE, no ERR. ABORT has priority over MEAS_ACK in the same cycle.
- ABORT coinciding with START in IDLE: START is ignored.

## Timing
- Reset values: MAIN_MODE=0, SUB_MODE=0, MEAS_REQ=0, BUSY=0, DONE=0, ERR=00; state IDLE; all counters 0.
- START sampled at edge E0: MAIN_MODE/SUB_MODE/BUSY are valid after E0. The stimulus outputs update after E1.
- MEAS_REQ rises after edge E0+SETTLE_CYC and falls after E0+SETTLE_CYC+max(DWELL,1).
- MEAS_ACK sampled at edge Ea (not the final step): the new mode is visible after Ea, and the next MEAS_REQ rises after Ea+SETTLE_CYC.
- Final MEAS_ACK at edge Ea: after Ea, DONE=1, BUSY=0, modes=0; DONE is low again after Ea+1.
- Timeout: ERR asserts ACK_TMO cycles after WAIT_ACK entry.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package ber_seq_pkg holds:
  - the state enum;
  - MODE_MIN=9, MODE_MAX=31, MODE_IDLE=0;
  - ERR code constants.
- Sub-module ber_seq_timer: a loadable down-counter with a zero flag. One instance is shared for settle, dwell and timeout because only one is active at a time. Width is max(DWELL_W, clog2(ACK_TMO+1), clog2(SETTLE_CYC+1)).
- Top level contains the FSM, main/sub step logic and the config latch.

## Test plan
- FIRST=13, LAST=14, SUB_LAST=1, DWELL=8, ACK 3 cycles after MEAS_REQ falls -> pairs (13,0),(13,1),(14,0),(14,1) in order; 4 MEAS_REQ windows of 8 cycles each; DONE once; modes return to 0.
- FIRST=20, LAST=10 -> ERR=01 for 1 cycle, BUSY stays 0; FIRST=8 -> same response.
- FIRST=LAST=31, SUB_LAST=0, DWELL=0 -> single window of 1 cycle; DONE after ACK.
- No ACK with ACK_TMO=1024 -> ERR=10 exactly 1024 cycles after WAIT_ACK entry; IDLE, modes 0.
- ABORT in the same cycle as MEAS_ACK on the second step -> IDLE next cycle, no DONE, no advance; a new START restarts at MAIN_FIRST, sub 0.
- RSTX asserted mid-MEAS -> all outputs take reset values immediately, without waiting for a CLK edge; START after release runs a full sweep.

Source files
------------

// File: rtl/ber_seq_pkg.sv
// Shared types and constants for the BER mode sweep sequencer.
package ber_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_MEAS     = 2'd2,
        ST_WAIT_ACK = 2'd3
    } state_t;

    localparam logic [7:0] MODE_MIN  = 8'd9;
    localparam logic [7:0] MODE_MAX  = 8'd31;
    localparam logic [7:0] MODE_IDLE = 8'd0;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CFG  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ber_mode_seq_if.sv
// Host/stimulus/BER-counter signal bundle for the mode sweep sequencer.
interface ber_mode_seq_if #(
    parameter int DWELL_W = 16
);
    logic               START;
    logic               ABORT;
    logic [7:0]         MAIN_FIRST;
    logic [7:0]         MAIN_LAST;
    logic [7:0]         SUB_LAST;
    logic [DWELL_W-1:0] DWELL;
    logic               MEAS_ACK;
    logic [7:0]         MAIN_MODE;
    logic [7:0]         SUB_MODE;
    logic               MEAS_REQ;
    logic               BUSY;
    logic               DONE;
    logic [1:0]         ERR;

    modport master (
        output START, ABORT, MAIN_FIRST, MAIN_LAST, SUB_LAST, DWELL, MEAS_ACK,
        input  MAIN_MODE, SUB_MODE, MEAS_REQ, BUSY, DONE, ERR
    );

    modport slave (
        input  START, ABORT, MAIN_FIRST, MAIN_LAST, SUB_LAST, DWELL, MEAS_ACK,
        output MAIN_MODE, SUB_MODE, MEAS_REQ, BUSY, DONE, ERR
    );

endinterface

// File: rtl/ber_seq_timer.sv
// Loadable down-counter that stops at zero; shared by settle, dwell and ack timeout.
module ber_seq_timer #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RSTX,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/ber_mode_seq.sv
// Sweeps MAIN_MODE/SUB_MODE over a latched range, opening one BER measurement
// window per pair and waiting for the counter's acknowledge before stepping.
module ber_mode_seq
    import ber_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int DWELL_W    = 16,
    parameter int ACK_TMO    = 1024
) (
    input  logic           CLK,
    input  logic           RSTX,
    ber_mode_seq_if.slave  bus
);

    localparam int TMR_W = max3(DWELL_W, $clog2(ACK_TMO + 1), $clog2(SETTLE_CYC + 1));

    // Timer counts down to zero, so each phase loads its length minus one.
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] TMO_LOAD    = TMR_W'(ACK_TMO - 1);

    state_t             state_q, state_d;
    logic [7:0]         main_q, main_d;
    logic [7:0]         sub_q, sub_d;
    logic [7:0]         main_last_q, main_last_d;
    logic [7:0]         sub_last_q, sub_last_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               meas_req_q, meas_req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         err_q, err_d;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_zero;
    logic               cfg_ok;
    logic [DWELL_W-1:0] dwell_m1;

    assign cfg_ok   = (bus.MAIN_FIRST >= MODE_MIN) &&
                      (bus.MAIN_FIRST <= bus.MAIN_LAST) &&
                      (bus.MAIN_LAST <= MODE_MAX);
    assign dwell_m1 = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

    ber_seq_timer #(.W(TMR_W)) u_timer (
        .CLK      (CLK),
        .RSTX     (RSTX),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        sub_d       = sub_q;
        main_last_d = main_last_q;
        sub_last_d  = sub_last_q;
        dwell_d     = dwell_q;
        done_d      = 1'b0;
        err_d       = ERR_NONE;
        tmr_load    = 1'b0;
        tmr_val     = SETTLE_LOAD;

        case (state_q)
            ST_IDLE: begin
                if (bus.START && !bus.ABORT) begin
                    if (cfg_ok) begin
                        main_last_d = bus.MAIN_LAST;
                        sub_last_d  = bus.SUB_LAST;
                        dwell_d     = bus.DWELL;
                        main_d      = bus.MAIN_FIRST;
                        sub_d       = 8'd0;
                        state_d     = ST_SETTLE;
                        tmr_load    = 1'b1;
                    end else begin
                        err_d = ERR_CFG;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d  = ST_MEAS;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(dwell_m1);
                end
            end
            ST_MEAS: begin
                if (tmr_zero) begin
                    state_d  = ST_WAIT_ACK;
                    tmr_load = 1'b1;
                    tmr_val  = TMO_LOAD;
                end
            end
            ST_WAIT_ACK: begin
                // An acknowledge on the final timeout cycle still counts.
                if (bus.MEAS_ACK) begin
                    if (main_q == main_last_q && sub_q == sub_last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        main_d  = MODE_IDLE;
                        sub_d   = MODE_IDLE;
                    end else begin
                        if (sub_q < sub_last_q) begin
                            sub_d = sub_q + 8'd1;
                        end else begin
                            sub_d  = 8'd0;
                            main_d = main_q + 8'd1;
                        end
                        state_d  = ST_SETTLE;
                        tmr_load = 1'b1;
                    end
                end else if (tmr_zero) begin
                    err_d   = ERR_TMO;
                    state_d = ST_IDLE;
                    main_d  = MODE_IDLE;
                    sub_d   = MODE_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                main_d  = MODE_IDLE;
                sub_d   = MODE_IDLE;
            end
        endcase

        if (bus.ABORT && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            main_d   = MODE_IDLE;
            sub_d    = MODE_IDLE;
            done_d   = 1'b0;
            err_d    = ERR_NONE;
            tmr_load = 1'b0;
        end

        meas_req_d = (state_d == ST_MEAS);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q     <= ST_IDLE;
            main_q      <= MODE_IDLE;
            sub_q       <= MODE_IDLE;
            main_last_q <= '0;
            sub_last_q  <= '0;
            dwell_q     <= '0;
            meas_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            sub_q       <= sub_d;
            main_last_q <= main_last_d;
            sub_last_q  <= sub_last_d;
            dwell_q     <= dwell_d;
            meas_req_q  <= meas_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.MAIN_MODE = main_q;
    assign bus.SUB_MODE  = sub_q;
    assign bus.MEAS_REQ  = meas_req_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;

endmodule

// File: tb/tb_ber_mode_seq.sv
// Scenario bench for ber_mode_seq: expected measurement windows are queued at
// START and popped as each MEAS_REQ window closes.
module tb_ber_mode_seq;

    localparam int SETTLE = 4;
    localparam int TMO    = 1024;

    logic clk  = 1'b0;
    logic rstx = 1'b0;
    always #5 clk = ~clk;

    ber_mode_seq_if #(.DWELL_W(16)) bus ();

    ber_mode_seq #(
        .SETTLE_CYC (SETTLE),
        .DWELL_W    (16),
        .ACK_TMO    (TMO)
    ) dut (
        .CLK  (clk),
        .RSTX (rstx),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0] m;
        logic [7:0] s;
        int         len;
    } win_t;

    win_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always @(negedge clk) if (bus.DONE === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000 ns");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep(input int first, input int last, input int sublast, input int dwell);
        win_t w;
        for (int m = first; m <= last; m++) begin
            for (int s = 0; s <= sublast; s++) begin
                w.m   = 8'(m);
                w.s   = 8'(s);
                w.len = (dwell == 0) ? 1 : dwell;
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic start_pulse(input int first, input int last, input int sublast, input int dwell);
        bus.MAIN_FIRST = 8'(first);
        bus.MAIN_LAST  = 8'(last);
        bus.SUB_LAST   = 8'(sublast);
        bus.DWELL      = 16'(dwell);
        bus.START      = 1'b1;
        tick();
        bus.START      = 1'b0;
    endtask

    task automatic send_ack(input int delay);
        repeat (delay) tick();
        bus.MEAS_ACK = 1'b1;
        tick();
        bus.MEAS_ACK = 1'b0;
    endtask

    // Called just after the edge that set a new mode; returns after MEAS_REQ falls.
    task automatic do_window(output bit ok);
        int settle = 0;
        int len = 0;
        logic [7:0] m, s;
        win_t e;
        ok = 1'b0;
        while (bus.MEAS_REQ !== 1'b1 && settle < 100) begin
            tick();
            settle++;
        end
        n_checks++;
        if (bus.MEAS_REQ !== 1'b1) begin
            n_fail++;
            $display("FAIL meas_req_rise: no rise after %0d cycles, required rise after %0d", settle, SETTLE);
            return;
        end
        if (settle != SETTLE) begin
            n_fail++;
            $display("FAIL settle_len: got %0d cycles, required %0d", settle, SETTLE);
        end
        m = bus.MAIN_MODE;
        s = bus.SUB_MODE;
        while (bus.MEAS_REQ === 1'b1 && len < 1000) begin
            len++;
            tick();
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL window_unexpected: got main=%0d sub=%0d len=%0d, required no window", m, s, len);
            return;
        end
        e = exp_q.pop_front();
        $display("window main=%0d sub=%0d len=%0d (expected main=%0d sub=%0d len=%0d)",
                 m, s, len, e.m, e.s, e.len);
        if (m !== e.m || s !== e.s || len != e.len) begin
            n_fail++;
            $display("FAIL window: got main=%0d sub=%0d len=%0d, required main=%0d sub=%0d len=%0d",
                     m, s, len, e.m, e.s, e.len);
        end
        ok = 1'b1;
    endtask

    task automatic run_sweep(input string name, input int first, input int last,
                             input int sublast, input int dwell, input int ack_delay);
        int d0;
        bit ok;
        win_t nx;
        exp_q.delete();
        push_sweep(first, last, sublast, dwell);
        d0 = done_cnt;
        start_pulse(first, last, sublast, dwell);
        n_checks++;
        if (bus.BUSY !== 1'b1 || bus.MAIN_MODE !== 8'(first) || bus.SUB_MODE !== 8'd0) begin
            n_fail++;
            $display("FAIL %s start_state: got busy=%b main=%0d sub=%0d, required busy=1 main=%0d sub=0",
                     name, bus.BUSY, bus.MAIN_MODE, bus.SUB_MODE, first);
        end
        while (exp_q.size() > 0) begin
            do_window(ok);
            if (!ok) return;
            send_ack(ack_delay);
            n_checks++;
            if (exp_q.size() > 0) begin
                nx = exp_q[0];
                if (bus.BUSY !== 1'b1 || bus.MAIN_MODE !== nx.m || bus.SUB_MODE !== nx.s) begin
                    n_fail++;
                    $display("FAIL %s step_mode: got busy=%b main=%0d sub=%0d, required busy=1 main=%0d sub=%0d",
                             name, bus.BUSY, bus.MAIN_MODE, bus.SUB_MODE, nx.m, nx.s);
                end
            end else begin
                if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0 || bus.MAIN_MODE !== 8'd0 || bus.SUB_MODE !== 8'd0) begin
                    n_fail++;
                    $display("FAIL %s done_pulse: got done=%b busy=%b main=%0d sub=%0d, required done=1 busy=0 main=0 sub=0",
                             name, bus.DONE, bus.BUSY, bus.MAIN_MODE, bus.SUB_MODE);
                end
                tick();
                n_checks++;
                if (bus.DONE !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s done_low: got done=%b, required 0", name, bus.DONE);
                end
            end
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d pulses, required 1", name, done_cnt - d0);
        end
        $display("%s: sweep %0d..%0d sub 0..%0d dwell %0d finished", name, first, last, sublast, dwell);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++;
        if (bus.MAIN_MODE !== 8'd0 || bus.SUB_MODE !== 8'd0 || bus.MEAS_REQ !== 1'b0 ||
            bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.ERR !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_values: got main=%0d sub=%0d req=%b busy=%b done=%b err=%b, required all 0",
                     bus.MAIN_MODE, bus.SUB_MODE, bus.MEAS_REQ, bus.BUSY, bus.DONE, bus.ERR);
        end
        #3 rstx = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.BUSY !== 1'b0 || bus.MEAS_REQ !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b req=%b, required 0 0", bus.BUSY, bus.MEAS_REQ);
        end
        $display("reset: outputs idle");
    endtask

    task automatic test_bad_config();
        int firsts[3] = '{20, 8, 9};
        int lasts[3]  = '{10, 12, 32};
        for (int i = 0; i < 3; i++) begin
            start_pulse(firsts[i], lasts[i], 1, 4);
            n_checks++;
            if (bus.ERR !== 2'b01 || bus.BUSY !== 1'b0 || bus.MAIN_MODE !== 8'd0) begin
                n_fail++;
                $display("FAIL bad_cfg_err: first=%0d last=%0d got err=%b busy=%b main=%0d, required err=01 busy=0 main=0",
                         firsts[i], lasts[i], bus.ERR, bus.BUSY, bus.MAIN_MODE);
            end
            tick();
            n_checks++;
            if (bus.ERR !== 2'b00 || bus.BUSY !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_cfg_clear: first=%0d last=%0d got err=%b busy=%b, required err=00 busy=0",
                         firsts[i], lasts[i], bus.ERR, bus.BUSY);
            end
            $display("bad config first=%0d last=%0d rejected", firsts[i], lasts[i]);
        end
    endtask

    task automatic test_timeout();
        int cnt = 0;
        int d0;
        bit ok;
        exp_q.delete();
        push_sweep(9, 9, 0, 2);
        d0 = done_cnt;
        start_pulse(9, 9, 0, 2);
        do_window(ok);
        if (!ok) return;
        while (bus.ERR === 2'b00 && cnt < 2000) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt != TMO || bus.ERR !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%b after %0d cycles, required err=10 after %0d", bus.ERR, cnt, TMO);
        end
        n_checks++;
        if (bus.BUSY !== 1'b0 || bus.MAIN_MODE !== 8'd0 || bus.SUB_MODE !== 8'd0 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL timeout_idle: got busy=%b main=%0d sub=%0d done_pulses=%0d, required 0 0 0 0",
                     bus.BUSY, bus.MAIN_MODE, bus.SUB_MODE, done_cnt - d0);
        end
        tick();
        n_checks++;
        if (bus.ERR !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_err_clear: got err=%b, required 00", bus.ERR);
        end
        $display("timeout: err after %0d cycles", cnt);
    endtask

    task automatic test_abort();
        int d0;
        int req_seen = 0;
        bit ok;
        exp_q.delete();
        push_sweep(10, 11, 2, 3);
        d0 = done_cnt;
        start_pulse(10, 11, 2, 3);
        do_window(ok);
        if (!ok) return;
        send_ack(1);
        do_window(ok);
        if (!ok) return;
        tick();
        bus.ABORT    = 1'b1;
        bus.MEAS_ACK = 1'b1;
        tick();
        bus.ABORT    = 1'b0;
        bus.MEAS_ACK = 1'b0;
        n_checks++;
        if (bus.BUSY !== 1'b0 || bus.MAIN_MODE !== 8'd0 || bus.SUB_MODE !== 8'd0 ||
            bus.MEAS_REQ !== 1'b0 || bus.ERR !== 2'b00 || bus.DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b main=%0d sub=%0d req=%b err=%b done=%b, required all 0",
                     bus.BUSY, bus.MAIN_MODE, bus.SUB_MODE, bus.MEAS_REQ, bus.ERR, bus.DONE);
        end
        repeat (SETTLE + 2) begin
            tick();
            if (bus.MEAS_REQ !== 1'b0 || bus.BUSY !== 1'b0) req_seen++;
        end
        n_checks++;
        if (req_seen != 0 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d active cycles, %0d done pulses, required 0 0", req_seen, done_cnt - d0);
        end
        $display("abort: sequencer idle after abort with ack");
        bus.ABORT = 1'b1;
        start_pulse(10, 11, 2, 3);
        bus.ABORT = 1'b0;
        n_checks++;
        if (bus.BUSY !== 1'b0 || bus.ERR !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_start: got busy=%b err=%b, required busy=0 err=00", bus.BUSY, bus.ERR);
        end
        tick();
        run_sweep("restart", 10, 11, 2, 3, 2);
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        exp_q.delete();
        start_pulse(12, 12, 0, 20);
        while (bus.MEAS_REQ !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        repeat (3) tick();
        #3 rstx = 1'b0;
        #1;
        n_checks++;
        if (bus.MAIN_MODE !== 8'd0 || bus.SUB_MODE !== 8'd0 || bus.MEAS_REQ !== 1'b0 ||
            bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.ERR !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset: got main=%0d sub=%0d req=%b busy=%b done=%b err=%b, required all 0",
                     bus.MAIN_MODE, bus.SUB_MODE, bus.MEAS_REQ, bus.BUSY, bus.DONE, bus.ERR);
        end
        #2 rstx = 1'b1;
        $display("reset mid-measurement: outputs cleared before next edge");
        tick();
        run_sweep("post_reset", 12, 13, 1, 5, 1);
    endtask

    initial begin
        bus.START      = 1'b0;
        bus.ABORT      = 1'b0;
        bus.MEAS_ACK   = 1'b0;
        bus.MAIN_FIRST = 8'd0;
        bus.MAIN_LAST  = 8'd0;
        bus.SUB_LAST   = 8'd0;
        bus.DWELL      = 16'd0;
        test_reset();
        run_sweep("basic", 13, 14, 1, 8, 3);
        test_bad_config();
        run_sweep("single", 31, 31, 0, 0, 2);
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
